// File: rtl/rsv_station.sv
// Reservation station for ALU-class instructions.
// Holds renamed instructions until both operands are present, snoops the ALU
// and load result buses to wake waiting operands, and issues the lowest-index
// ready entry to the ALU once per cycle.
//
// Handshake: the dispatcher treats rs_full as its ready signal one cycle
// early. rs_full already counts an rs_ena of the current cycle, so the
// instruction sitting in the dispatcher's output register always has a slot.
// Issue has no back-pressure: alu_ena is a one-cycle valid pulse per issued
// instruction, and the ALU must accept it.
module rsv_station #(
  parameter int RS_SIZE   = 16,
  parameter int ROB_IDX_W = 4,
  parameter int OPT_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rb,
  input  logic                 rs_ena,
  input  logic [OPT_W-1:0]     rs_opt,
  input  logic [ROB_IDX_W-1:0] rs_src1,
  input  logic [ROB_IDX_W-1:0] rs_src2,
  input  logic [31:0]          rs_val1,
  input  logic [31:0]          rs_val2,
  input  logic [31:0]          rs_imm,
  input  logic [ROB_IDX_W-1:0] rs_rob_idx,
  output logic                 rs_full,
  input  logic                 cdb_alu_valid,
  input  logic [ROB_IDX_W-1:0] cdb_alu_src,
  input  logic [31:0]          cdb_alu_val,
  input  logic                 cdb_ld_valid,
  input  logic [ROB_IDX_W-1:0] cdb_ld_src,
  input  logic [31:0]          cdb_ld_val,
  output logic                 alu_ena,
  output logic [OPT_W-1:0]     alu_opt,
  output logic [31:0]          alu_val1,
  output logic [31:0]          alu_val2,
  output logic [31:0]          alu_imm,
  output logic [ROB_IDX_W-1:0] alu_rob_idx
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0]     FULL_CNT     = CNT_W'(RS_SIZE);
  localparam logic [ROB_IDX_W-1:0] ZERO_ROB_IDX = '0;

  // Entry storage: busy bits are reset, payload is only meaningful while busy.
  logic [RS_SIZE-1:0]   busy_q, busy_d;
  logic [OPT_W-1:0]     opt_q [RS_SIZE];
  logic [OPT_W-1:0]     opt_d [RS_SIZE];
  logic [ROB_IDX_W-1:0] q1_q  [RS_SIZE];
  logic [ROB_IDX_W-1:0] q1_d  [RS_SIZE];
  logic [ROB_IDX_W-1:0] q2_q  [RS_SIZE];
  logic [ROB_IDX_W-1:0] q2_d  [RS_SIZE];
  logic [31:0]          v1_q  [RS_SIZE];
  logic [31:0]          v1_d  [RS_SIZE];
  logic [31:0]          v2_q  [RS_SIZE];
  logic [31:0]          v2_d  [RS_SIZE];
  logic [31:0]          imm_q [RS_SIZE];
  logic [31:0]          imm_d [RS_SIZE];
  logic [ROB_IDX_W-1:0] rob_q [RS_SIZE];
  logic [ROB_IDX_W-1:0] rob_d [RS_SIZE];

  // Issue register
  logic                 alu_ena_q;
  logic [OPT_W-1:0]     alu_opt_q;
  logic [31:0]          alu_val1_q;
  logic [31:0]          alu_val2_q;
  logic [31:0]          alu_imm_q;
  logic [ROB_IDX_W-1:0] alu_rob_q;

  logic [RS_SIZE-1:0] ready;
  logic               issue_found;
  logic [IDX_W-1:0]   issue_idx;
  logic               alloc_found;
  logic [IDX_W-1:0]   alloc_idx;
  logic [CNT_W-1:0]   busy_cnt;
  logic [CNT_W-1:0]   occ_sum;

  // Ready vector, lowest-index issue/free selection and occupancy, all taken
  // from the state at the start of the cycle.
  always_comb begin
    ready       = '0;
    issue_found = 1'b0;
    issue_idx   = '0;
    alloc_found = 1'b0;
    alloc_idx   = '0;
    busy_cnt    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      ready[i] = busy_q[i] && (q1_q[i] == ZERO_ROB_IDX) && (q2_q[i] == ZERO_ROB_IDX);
      if (ready[i]) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i);
      end
      if (!busy_q[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
      busy_cnt = busy_cnt + CNT_W'(busy_q[i]);
    end
  end

  // The in-flight dispatch is counted so the dispatcher never overflows us.
  assign occ_sum = busy_cnt + CNT_W'(rs_ena);
  assign rs_full = (occ_sum >= FULL_CNT);

  // Next entry state: flush, operand wakeup, issue release and allocation.
  always_comb begin
    busy_d = busy_q;
    opt_d  = opt_q;
    q1_d   = q1_q;
    q2_d   = q2_q;
    v1_d   = v1_q;
    v2_d   = v2_q;
    imm_d  = imm_q;
    rob_d  = rob_q;
    if (rb) begin
      busy_d = '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && (q1_q[i] != ZERO_ROB_IDX)) begin
          if (cdb_alu_valid && (cdb_alu_src == q1_q[i])) begin
            q1_d[i] = ZERO_ROB_IDX;
            v1_d[i] = cdb_alu_val;
          end else if (cdb_ld_valid && (cdb_ld_src == q1_q[i])) begin
            q1_d[i] = ZERO_ROB_IDX;
            v1_d[i] = cdb_ld_val;
          end
        end
        if (busy_q[i] && (q2_q[i] != ZERO_ROB_IDX)) begin
          if (cdb_alu_valid && (cdb_alu_src == q2_q[i])) begin
            q2_d[i] = ZERO_ROB_IDX;
            v2_d[i] = cdb_alu_val;
          end else if (cdb_ld_valid && (cdb_ld_src == q2_q[i])) begin
            q2_d[i] = ZERO_ROB_IDX;
            v2_d[i] = cdb_ld_val;
          end
        end
      end
      if (issue_found) begin
        busy_d[issue_idx] = 1'b0;
      end
      // alloc_idx comes from the pre-issue free set, so it never equals issue_idx.
      if (rs_ena && alloc_found) begin
        busy_d[alloc_idx] = 1'b1;
        opt_d[alloc_idx]  = rs_opt;
        imm_d[alloc_idx]  = rs_imm;
        rob_d[alloc_idx]  = rs_rob_idx;
        q1_d[alloc_idx]   = rs_src1;
        v1_d[alloc_idx]   = rs_val1;
        q2_d[alloc_idx]   = rs_src2;
        v2_d[alloc_idx]   = rs_val2;
        if (rs_src1 != ZERO_ROB_IDX) begin
          if (cdb_alu_valid && (cdb_alu_src == rs_src1)) begin
            q1_d[alloc_idx] = ZERO_ROB_IDX;
            v1_d[alloc_idx] = cdb_alu_val;
          end else if (cdb_ld_valid && (cdb_ld_src == rs_src1)) begin
            q1_d[alloc_idx] = ZERO_ROB_IDX;
            v1_d[alloc_idx] = cdb_ld_val;
          end
        end
        if (rs_src2 != ZERO_ROB_IDX) begin
          if (cdb_alu_valid && (cdb_alu_src == rs_src2)) begin
            q2_d[alloc_idx] = ZERO_ROB_IDX;
            v2_d[alloc_idx] = cdb_alu_val;
          end else if (cdb_ld_valid && (cdb_ld_src == rs_src2)) begin
            q2_d[alloc_idx] = ZERO_ROB_IDX;
            v2_d[alloc_idx] = cdb_ld_val;
          end
        end
      end
    end
  end

  // Busy bits: cleared by reset, frozen while rdy is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else if (rdy) begin
      busy_q <= busy_d;
    end
  end

  // Entry payload: no reset needed, gated by rdy like the busy bits.
  always_ff @(posedge clk) begin
    if (rdy) begin
      opt_q <= opt_d;
      q1_q  <= q1_d;
      q2_q  <= q2_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      imm_q <= imm_d;
      rob_q <= rob_d;
    end
  end

  // Issue register: pulse alu_ena for one cycle, hold data when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_ena_q  <= 1'b0;
      alu_opt_q  <= '0;
      alu_val1_q <= '0;
      alu_val2_q <= '0;
      alu_imm_q  <= '0;
      alu_rob_q  <= '0;
    end else if (rdy && !rb && issue_found) begin
      alu_ena_q  <= 1'b1;
      alu_opt_q  <= opt_q[issue_idx];
      alu_val1_q <= v1_q[issue_idx];
      alu_val2_q <= v2_q[issue_idx];
      alu_imm_q  <= imm_q[issue_idx];
      alu_rob_q  <= rob_q[issue_idx];
    end else begin
      alu_ena_q  <= 1'b0;
    end
  end

  assign alu_ena     = alu_ena_q;
  assign alu_opt     = alu_opt_q;
  assign alu_val1    = alu_val1_q;
  assign alu_val2    = alu_val2_q;
  assign alu_imm     = alu_imm_q;
  assign alu_rob_idx = alu_rob_q;

  // A dispatch into a completely full station means the dispatcher ignored rs_full.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    (rdy && !rb && rs_ena) |-> !(&busy_q));

endmodule

// File: tb/tb_rsv_station.sv
// Bench for rsv_station: directed scenarios followed by random traffic, all
// compared cycle by cycle against an entry-table model of the station.
module tb_rsv_station;

  localparam int RS_SIZE   = 16;
  localparam int ROB_IDX_W = 4;
  localparam int OPT_W     = 6;
  localparam int PKT_W     = OPT_W + 32 * 3 + ROB_IDX_W;

  logic                 clk;
  logic                 rst;
  logic                 rdy;
  logic                 rb;
  logic                 rs_ena;
  logic [OPT_W-1:0]     rs_opt;
  logic [ROB_IDX_W-1:0] rs_src1, rs_src2, rs_rob_idx;
  logic [31:0]          rs_val1, rs_val2, rs_imm;
  logic                 rs_full;
  logic                 cdb_alu_valid, cdb_ld_valid;
  logic [ROB_IDX_W-1:0] cdb_alu_src, cdb_ld_src;
  logic [31:0]          cdb_alu_val, cdb_ld_val;
  logic                 alu_ena;
  logic [OPT_W-1:0]     alu_opt;
  logic [31:0]          alu_val1, alu_val2, alu_imm;
  logic [ROB_IDX_W-1:0] alu_rob_idx;

  rsv_station #(.RS_SIZE(RS_SIZE), .ROB_IDX_W(ROB_IDX_W), .OPT_W(OPT_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rb(rb),
    .rs_ena(rs_ena), .rs_opt(rs_opt), .rs_src1(rs_src1), .rs_src2(rs_src2),
    .rs_val1(rs_val1), .rs_val2(rs_val2), .rs_imm(rs_imm), .rs_rob_idx(rs_rob_idx),
    .rs_full(rs_full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_src(cdb_alu_src), .cdb_alu_val(cdb_alu_val),
    .cdb_ld_valid(cdb_ld_valid), .cdb_ld_src(cdb_ld_src), .cdb_ld_val(cdb_ld_val),
    .alu_ena(alu_ena), .alu_opt(alu_opt), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_imm(alu_imm), .alu_rob_idx(alu_rob_idx)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic                 busy;
    logic [OPT_W-1:0]     opt;
    logic [ROB_IDX_W-1:0] q1, q2;
    logic [31:0]          v1, v2, imm;
    logic [ROB_IDX_W-1:0] rob;
  } ent_t;

  ent_t             m [RS_SIZE];
  logic             m_ena;
  logic [PKT_W-1:0] m_last;
  logic [PKT_W-1:0] exp_q [$];
  int               n_checks;
  int               n_fail;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < RS_SIZE; i++) if (m[i].busy) c++;
    return c;
  endfunction

  // A waiting tag resolves against the buses; ALU bus takes priority.
  function automatic logic [35:0] resolve(input logic [3:0] q, input logic [31:0] v);
    if (q != 4'd0 && cdb_alu_valid && cdb_alu_src == q) return {4'd0, cdb_alu_val};
    if (q != 4'd0 && cdb_ld_valid && cdb_ld_src == q)   return {4'd0, cdb_ld_val};
    return {q, v};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
    m_ena  = 1'b0;
    m_last = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    ent_t        nx [RS_SIZE];
    int          iss;
    int          fr;
    logic [35:0] r;
    nx  = m;
    iss = -1;
    fr  = -1;
    if (!rst) begin
      model_reset();
      return;
    end
    if (!rdy) begin
      m_ena = 1'b0;
      return;
    end
    if (rb) begin
      for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
      m_ena = 1'b0;
      return;
    end
    for (int i = 0; i < RS_SIZE; i++) begin
      if (iss < 0 && m[i].busy && m[i].q1 == 0 && m[i].q2 == 0) iss = i;
      if (fr < 0 && !m[i].busy) fr = i;
      if (m[i].busy) begin
        r = resolve(m[i].q1, m[i].v1); nx[i].q1 = r[35:32]; nx[i].v1 = r[31:0];
        r = resolve(m[i].q2, m[i].v2); nx[i].q2 = r[35:32]; nx[i].v2 = r[31:0];
      end
    end
    if (iss >= 0) begin
      nx[iss].busy = 1'b0;
      m_ena  = 1'b1;
      m_last = {m[iss].opt, m[iss].v1, m[iss].v2, m[iss].imm, m[iss].rob};
      exp_q.push_back(m_last);
    end else begin
      m_ena = 1'b0;
    end
    if (rs_ena && fr >= 0) begin
      nx[fr].busy = 1'b1;
      nx[fr].opt  = rs_opt;
      nx[fr].imm  = rs_imm;
      nx[fr].rob  = rs_rob_idx;
      r = resolve(rs_src1, rs_val1); nx[fr].q1 = r[35:32]; nx[fr].v1 = r[31:0];
      r = resolve(rs_src2, rs_val2); nx[fr].q2 = r[35:32]; nx[fr].v2 = r[31:0];
    end
    m = nx;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    rdy = 1'b1; rb = 1'b0; rs_ena = 1'b0;
    cdb_alu_valid = 1'b0; cdb_ld_valid = 1'b0;
  endtask

  task automatic dispatch(input logic [3:0] s1, input logic [31:0] v1,
                          input logic [3:0] s2, input logic [31:0] v2,
                          input logic [3:0] rob);
    rs_ena = 1'b1; rs_opt = OPT_W'($urandom_range(0, 63));
    rs_src1 = s1; rs_val1 = v1; rs_src2 = s2; rs_val2 = v2;
    rs_imm = $urandom; rs_rob_idx = rob;
  endtask

  // One clock cycle: inputs are set at the preceding negedge.
  task automatic tick();
    logic [PKT_W-1:0] pkt;
    #1;
    check("rs_full", 128'(rs_full), 128'((m_count() + int'(rs_ena)) >= RS_SIZE));
    model_step();
    @(posedge clk);
    #1;
    check("alu_ena", 128'(alu_ena), 128'(m_ena));
    if (alu_ena) begin
      if (exp_q.size() == 0) begin
        check("issue_unexpected", 128'(1), 128'(0));
      end else begin
        pkt = exp_q.pop_front();
        check("issue_pkt", 128'({alu_opt, alu_val1, alu_val2, alu_imm, alu_rob_idx}), 128'(pkt));
      end
    end
    check("alu_data", 128'({alu_opt, alu_val1, alu_val2, alu_imm, alu_rob_idx}), 128'(m_last));
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    set_idle();
    rs_opt = '0; rs_src1 = '0; rs_src2 = '0; rs_val1 = '0; rs_val2 = '0;
    rs_imm = '0; rs_rob_idx = '0;
    cdb_alu_src = '0; cdb_alu_val = '0; cdb_ld_src = '0; cdb_ld_val = '0;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    check("reset_alu_ena", 128'(alu_ena), 128'(0));
    rst = 1'b1;

    // Some activity, then an asynchronous reset mid-run.
    for (int i = 0; i < 6; i++) begin
      set_idle();
      dispatch(4'd0, 32'(i + 1), 4'd0, 32'(i + 2), 4'(i));
      tick();
    end
    set_idle();
    rst = 1'b0;
    #1;
    check("rst_alu_ena", 128'(alu_ena), 128'(0));
    check("rst_alu_data", 128'({alu_opt, alu_val1, alu_val2, alu_imm, alu_rob_idx}), 128'(0));
    check("rst_full", 128'(rs_full), 128'(0));
    model_reset();
    tick();
    rst = 1'b1;

    // Basic issue: ready entry issues one cycle after being stored.
    set_idle();
    dispatch(4'd0, 32'd5, 4'd0, 32'd7, 4'd3);
    rs_opt = 6'h01;
    tick();
    set_idle();
    tick();
    check("basic_ena", 128'(alu_ena), 128'(1));
    check("basic_val1", 128'(alu_val1), 128'(5));
    check("basic_val2", 128'(alu_val2), 128'(7));
    check("basic_rob", 128'(alu_rob_idx), 128'(3));
    check("basic_opt", 128'(alu_opt), 128'(1));

    // Dependency wakeup through the ALU bus.
    set_idle();
    dispatch(4'd4, 32'hdead, 4'd0, 32'd1, 4'd2);
    tick();
    set_idle();
    tick();
    cdb_alu_valid = 1'b1; cdb_alu_src = 4'd4; cdb_alu_val = 32'h1234;
    tick();
    set_idle();
    tick();
    check("wake_ena", 128'(alu_ena), 128'(1));
    check("wake_val1", 128'(alu_val1), 128'(32'h1234));

    // Same-cycle forward from the load bus.
    set_idle();
    dispatch(4'd0, 32'd9, 4'd6, 32'h0, 4'd5);
    cdb_ld_valid = 1'b1; cdb_ld_src = 4'd6; cdb_ld_val = 32'hBEEF;
    tick();
    set_idle();
    tick();
    check("fwd_ena", 128'(alu_ena), 128'(1));
    check("fwd_val2", 128'(alu_val2), 128'(32'hBEEF));

    // Both buses hit the same tag: the ALU value wins.
    set_idle();
    dispatch(4'd5, 32'h0, 4'd0, 32'd3, 4'd7);
    tick();
    set_idle();
    cdb_alu_valid = 1'b1; cdb_alu_src = 4'd5; cdb_alu_val = 32'hA1A1;
    cdb_ld_valid  = 1'b1; cdb_ld_src  = 4'd5; cdb_ld_val  = 32'hB2B2;
    tick();
    set_idle();
    tick();
    check("both_val1", 128'(alu_val1), 128'(32'hA1A1));

    // Fill all entries behind tag 9, then drain lowest-index first.
    set_idle();
    for (int i = 0; i < RS_SIZE - 1; i++) begin
      dispatch(4'd9, 32'd0, 4'd0, 32'(i), 4'(i));
      tick();
    end
    dispatch(4'd9, 32'd0, 4'd0, 32'd15, 4'd15);
    #1;
    check("full_16th", 128'(rs_full), 128'(1));
    tick();
    set_idle();
    #1;
    check("full_after", 128'(rs_full), 128'(1));
    cdb_alu_valid = 1'b1; cdb_alu_src = 4'd9; cdb_alu_val = 32'h99;
    tick();
    set_idle();
    for (int i = 0; i < RS_SIZE; i++) begin
      tick();
      check("drain_ena", 128'(alu_ena), 128'(1));
      check("drain_order", 128'(alu_rob_idx), 128'(i));
      if (i == 0) begin
        #1;
        check("full_drop", 128'(rs_full), 128'(0));
      end
    end

    // Rollback drops busy entries and the concurrent dispatch.
    set_idle();
    for (int i = 0; i < 5; i++) begin
      dispatch(4'd9, 32'd0, 4'd0, 32'd0, 4'(i));
      tick();
    end
    dispatch(4'd0, 32'd1, 4'd0, 32'd2, 4'd8);
    rb = 1'b1;
    tick();
    set_idle();
    cdb_alu_valid = 1'b1; cdb_alu_src = 4'd9; cdb_alu_val = 32'h1;
    tick();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rb_no_issue", 128'(alu_ena), 128'(0));
    end
    #1;
    check("rb_full", 128'(rs_full), 128'(0));

    // rdy freeze with ready entries present.
    set_idle();
    for (int i = 0; i < 4; i++) begin
      dispatch(4'd0, 32'(i), 4'd0, 32'(i), 4'(i + 10));
      tick();
    end
    set_idle();
    rdy = 1'b0;
    dispatch(4'd0, 32'd7, 4'd0, 32'd7, 4'd1);
    cdb_alu_valid = 1'b1; cdb_alu_src = 4'd3; cdb_alu_val = 32'h5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freeze_no_issue", 128'(alu_ena), 128'(0));
    end
    set_idle();
    tick();
    check("freeze_resume", 128'(alu_ena), 128'(1));

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 99) < 92);
      rb  = ($urandom_range(0, 99) < 2);
      rs_ena = ($urandom_range(0, 99) < 60) && (m_count() < RS_SIZE);
      rs_opt = OPT_W'($urandom_range(0, 63));
      rs_src1 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 7));
      rs_src2 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 7));
      rs_val1 = $urandom; rs_val2 = $urandom; rs_imm = $urandom;
      rs_rob_idx = 4'($urandom_range(0, 15));
      cdb_alu_valid = ($urandom_range(0, 99) < 40);
      cdb_alu_src = 4'($urandom_range(0, 7)); cdb_alu_val = $urandom;
      cdb_ld_valid = ($urandom_range(0, 99) < 30);
      cdb_ld_src = 4'($urandom_range(0, 7)); cdb_ld_val = $urandom;
      tick();
    end

    // Let everything still pending drain.
    set_idle();
    cdb_alu_valid = 1'b0;
    rb = 1'b1;
    tick();
    set_idle();
    tick();
    check("exp_q_empty", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rsv_station.md
# rsv_station

Reservation station for ALU-class instructions, placed directly downstream of the dispatcher in the out-of-order core. It accepts one dispatched instruction per cycle with renamed operands. It snoops the ALU and load CDB buses to wake pending operands. Each cycle it issues at most one ready entry to the ALU, and it back-pressures the dispatcher through `rs_full`.

## Interface
- `RS_SIZE`, 16: number of entries; power of two, at least 4.
- `ROB_IDX_W`, 4: ROB tag width. Tag 0 is `ZERO_ROB_IDX` and means "value present, no dependency".
- `OPT_W`, 6: opcode (`INST_OPT`) width.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `rdy` in 1: global ready; low freezes the block.
- `rb` in 1: rollback/flush; synchronous, active-high.
- `rs_ena` in 1: dispatcher write strobe.
- `rs_opt` in OPT_W: opcode.
- `rs_src1`, `rs_src2` in ROB_IDX_W: producer tags; 0 means ready.
- `rs_val1`, `rs_val2` in 32: operand values; valid when the matching tag is 0.
- `rs_imm` in 32: immediate.
- `rs_rob_idx` in ROB_IDX_W: destination ROB tag.
- `rs_full` out 1: back-pressure to the dispatcher.
- `cdb_alu_valid` in 1, `cdb_alu_src` in ROB_IDX_W, `cdb_alu_val` in 32: ALU result broadcast.
- `cdb_ld_valid` in 1, `cdb_ld_src` in ROB_IDX_W, `cdb_ld_val` in 32: load result broadcast.
- `alu_ena` out 1: issue strobe.
- `alu_opt` out OPT_W, `alu_val1` out 32, `alu_val2` out 32, `alu_imm` out 32, `alu_rob_idx` out ROB_IDX_W: issued operands.

## Operation
- **Entry state:** each entry holds `busy`, `opt`, `q1`, `q2`, `v1`, `v2`, `imm`, `rob_idx`. An entry is ready when `busy && q1==0 && q2==0`.
- **Precedence** (highest first): `rst` low, then `rdy` low, then `rb`, then normal operation.
- **Reset:**
  - All `busy` bits clear.
  - `alu_ena`=0; every `alu_*` data output is 0.
  - `rs_full`=0.
- **`rdy` low:**
  - No entry changes.
  - `rs_ena` and CDB inputs are ignored.
  - `alu_ena` is registered 0.
- **`rb` high (with `rdy` high):**
  - All `busy` bits clear at the edge.
  - `rs_ena` in the same cycle is dropped.
  - `alu_ena` is registered 0.
- **Allocate:**
  - On `rs_ena`, write the lowest-index non-busy entry.
  - Incoming operands are forwarded from the same-cycle CDB: if the valid bus tag equals a nonzero `rs_srcN`, store `qN`=0 and `vN`=bus value.
- **Wakeup:**
  - For every busy entry with `qN`≠0 matching a valid CDB tag, set `qN`=0 and `vN`=bus value at the edge.
  - ALU and load buses are checked independently. If both match (illegal), the ALU bus wins.
- **Issue:**
  - Select the lowest-index ready entry, judged on the register state at the start of the cycle.
  - Register its fields onto `alu_*` with `alu_ena`=1 and clear its `busy` bit.
  - With no ready entry, `alu_ena`=0 and the data outputs hold their last values.
- **Same-cycle interactions:**
  - One entry may be freed by issue and another allocated in the same cycle. Allocation uses the pre-issue free set, so the issuing slot is not reused that cycle.
- **`rs_full`:**
  - Combinational: `rs_full` = (busy count + `rs_ena`) ≥ RS_SIZE.
  - This covers the one instruction in flight in the dispatcher's output register, so overflow is impossible when the dispatcher obeys `rs_full`.
  - An `rs_ena` arriving with every entry busy is a protocol violation: it is dropped, and simulation asserts.

## Timing
- **Dispatch:** the dispatcher samples `rs_full` in cycle N and drives `rs_ena` in N+1; the entry is stored at the end of N+1.
- **Issue latency:** an entry stored ready at edge E is issued on `alu_*` after edge E+1, giving 1 cycle of residence minimum.
- **Wakeup latency:** a CDB broadcast in cycle N makes the dependent entry ready in N+1, so issue is visible after edge N+1.
- **Throughput:** one allocation and one issue per cycle, sustained.
- **`alu_ena` pulse:** high for exactly one cycle per issued instruction.

## Test plan
- **Reset and basic issue:** `rst` low mid-run → all outputs 0 immediately; after release, write {opt=ADD, src1=0, val1=5, src2=0, val2=7, rob=3} → `alu_ena`=1 one cycle later with val1=5, val2=7, rob_idx=3.
- **Dependency wakeup:** write src1=4, then `cdb_alu_valid` with src=4, val=0x1234 two cycles later → issue in the following cycle with `alu_val1`=0x1234.
- **Same-cycle forward:** `rs_ena` with src2=6 while `cdb_ld_valid` src=6, val=0xBEEF → entry stored ready, issued next cycle with val2=0xBEEF.
- **Full:** fill 15 entries all dependent on tag 9 → `rs_full`=1 while the 16th `rs_ena` is high; after the 16th write `rs_full` stays 1; a broadcast of tag 9 drains the entries lowest-index first, one per cycle, with `rs_full` dropping after the first issue.
- **Rollback:** 5 busy entries, pulse `rb` with `rs_ena`=1 → no `alu_ena` afterwards, busy count 0, `rs_full`=0.
- **`rdy` freeze:** hold `rdy` low 3 cycles with ready entries present → no issue and no state change; issue resumes the cycle after `rdy` returns.
